// File: rtl/mdu_unit_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: op encodings,
// default latencies and the arithmetic helpers used by mdu_unit.
package mdu_unit_pkg;

  // MDU operation encodings as carried on E_MDUOp
  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5
  } mdu_op_e;

  localparam int unsigned MDU_MULT_CYCLES_DEF = 5;
  localparam int unsigned MDU_DIV_CYCLES_DEF  = 10;

  // Full 64-bit product; signed operands are sign-extended to 64 bits so the
  // low 64 bits of the unsigned product equal the two's-complement product.
  function automatic logic [63:0] mdu_mul(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic [63:0] xa;
    logic [63:0] xb;
    xa = {{32{is_signed & a[31]}}, a};
    xb = {{32{is_signed & b[31]}}, b};
    return xa * xb;
  endfunction

  // Returns {remainder, quotient}. Signed division works on magnitudes so the
  // quotient truncates toward zero and the remainder takes the dividend sign.
  // Caller must not rely on the result when b is zero.
  function automatic logic [63:0] mdu_div(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        is_signed);
    logic        neg_a;
    logic        neg_b;
    logic [31:0] ma;
    logic [31:0] mb;
    logic [31:0] q;
    logic [31:0] r;
    neg_a = is_signed & a[31];
    neg_b = is_signed & b[31];
    ma    = neg_a ? (~a + 32'd1) : a;
    mb    = neg_b ? (~b + 32'd1) : b;
    q     = ma / mb;
    r     = ma % mb;
    if (neg_a ^ neg_b) q = ~q + 32'd1;
    if (neg_a)         r = ~r + 32'd1;
    return {r, q};
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: fixed-latency MULT/MULTU/DIV/DIVU with
// result held in pending registers until commit, MTHI/MTLO writes, and the
// MD stall term consumed by the hazard unit.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MDU_MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [2:0]  E_MDUOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        E_HILOWr,
  input  logic        D_IsMD,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO,
  output logic        E_Busy,
  output logic        MD_Stall
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  mdu_op_e          op;
  logic [CNT_W-1:0] count;
  logic             busy_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic             pend_wr;

  logic             launch;
  logic [CNT_W-1:0] launch_cnt;
  logic             res_wr;
  logic [63:0]      res;

  assign op = mdu_op_e'(E_MDUOp);

  // Decode a start request and compute the result to be parked in pending regs
  always_comb begin
    launch     = 1'b0;
    launch_cnt = '0;
    res_wr     = 1'b0;
    res        = '0;
    if (E_Start && !busy_q) begin
      case (op)
        MDU_MULT, MDU_MULTU: begin
          launch     = 1'b1;
          launch_cnt = CNT_W'(MULT_CYCLES);
          res_wr     = 1'b1;
          res        = mdu_mul(E_A, E_B, op == MDU_MULT);
        end
        MDU_DIV, MDU_DIVU: begin
          launch     = 1'b1;
          launch_cnt = CNT_W'(DIV_CYCLES);
          // Divide by zero still occupies the unit but commits nothing
          res_wr     = (E_B != '0);
          if (E_B != '0) res = mdu_div(E_A, E_B, op == MDU_DIV);
        end
        default: ;
      endcase
    end
  end

  // Busy countdown, commit of pending result, and MTHI/MTLO writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_wr <= 1'b0;
    end else if (busy_q) begin
      // Any new request while busy is dropped so the in-flight op is untouched
      if (count == CNT_W'(1)) begin
        busy_q <= 1'b0;
        count  <= '0;
        if (pend_wr) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
      end else begin
        count <= count - 1'b1;
      end
    end else if (E_Start) begin
      // Start has priority over a same-cycle MTHI/MTLO; unknown ops are no-ops
      if (launch) begin
        busy_q  <= 1'b1;
        count   <= launch_cnt;
        pend_wr <= res_wr;
        pend_hi <= res[63:32];
        pend_lo <= res[31:0];
      end
    end else if (E_HILOWr) begin
      case (op)
        MDU_MTHI: hi_q <= E_A;
        MDU_MTLO: lo_q <= E_A;
        default: ;
      endcase
    end
  end

  assign E_HI     = hi_q;
  assign E_LO     = lo_q;
  assign E_Busy   = busy_q;
  assign MD_Stall = D_IsMD & (E_Start | busy_q);

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: a driver issues directed operations and
// queues the hand-computed HI/LO expected at completion; a monitor pops and
// compares whenever the unit completes (busy falls, or an MTHI/MTLO lands).
module tb_mdu_unit;
  import mdu_unit_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_Start;
  logic [2:0]  E_MDUOp;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        E_HILOWr;
  logic        D_IsMD;
  logic [31:0] E_HI;
  logic [31:0] E_LO;
  logic        E_Busy;
  logic        MD_Stall;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   mt_cnt  = 0;
  int   mt_done = 0;

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .E_Start  (E_Start),
    .E_MDUOp  (E_MDUOp),
    .E_A      (E_A),
    .E_B      (E_B),
    .E_HILOWr (E_HILOWr),
    .D_IsMD   (D_IsMD),
    .E_HI     (E_HI),
    .E_LO     (E_LO),
    .E_Busy   (E_Busy),
    .MD_Stall (MD_Stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples shortly after each falling edge and scores completions
  initial begin : monitor
    logic prev_busy;
    exp_t e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if ((prev_busy && !E_Busy) || (mt_done < mt_cnt)) begin
        if (mt_done < mt_cnt) mt_done++;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: completion seen with empty queue, HI=%h LO=%h", E_HI, E_LO);
        end else begin
          e = sb.pop_front();
          check({e.name, " HI"}, E_HI, e.hi);
          check({e.name, " LO"}, E_LO, e.lo);
        end
      end
      prev_busy = E_Busy;
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    exp_t e;
    @(negedge clk);
    E_Start = 1'b1;
    E_MDUOp = op;
    E_A     = a;
    E_B     = b;
    e.name = name; e.hi = exp_hi; e.lo = exp_lo;
    sb.push_back(e);
    @(negedge clk);
    E_Start = 1'b0;
  endtask

  // Counts busy cycles from the current falling edge until idle, bounded
  task automatic wait_idle(input int exp_n, input string name);
    int n;
    n = 0;
    while (E_Busy === 1'b1 && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, 32'(n), 32'(exp_n));
  endtask

  task automatic mt_write(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
    exp_t e;
    @(negedge clk);
    E_HILOWr = 1'b1;
    E_MDUOp  = op;
    E_A      = a;
    e.name = name; e.hi = exp_hi; e.lo = exp_lo;
    sb.push_back(e);
    @(negedge clk);
    E_HILOWr = 1'b0;
    mt_cnt++;
    check({name, " busy"}, 32'(E_Busy), 32'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    reset = 1'b1; E_Start = 1'b0; E_MDUOp = '0; E_A = '0; E_B = '0;
    E_HILOWr = 1'b0; D_IsMD = 1'b0;
    #1;
    check("reset HI", E_HI, 32'h0);
    check("reset LO", E_LO, 32'h0);
    check("reset busy", 32'(E_Busy), 32'd0);
    check("reset stall", 32'(MD_Stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Idle with an MD instr in decode: no stall
    @(negedge clk);
    D_IsMD = 1'b1;
    #1 check("stall idle", 32'(MD_Stall), 32'd0);

    // MULT with MD in decode: stall in the same cycle as the start
    @(negedge clk);
    E_Start = 1'b1; E_MDUOp = MDU_MULT; E_A = 32'hFFFFFFFF; E_B = 32'd2;
    sb.push_back('{"mult -1*2", 32'hFFFFFFFF, 32'hFFFFFFFE});
    #1 check("stall on start", 32'(MD_Stall), 32'd1);
    @(negedge clk);
    E_Start = 1'b0; D_IsMD = 1'b0;
    #1 check("stall no D md", 32'(MD_Stall), 32'd0);
    check("hi held while busy", E_HI, 32'h0);
    wait_idle(5, "mult -1*2");

    issue(MDU_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, "multu ffffffff*2");
    wait_idle(5, "multu");
    issue(MDU_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div -7/2");
    wait_idle(10, "div -7/2");
    issue(MDU_DIVU, 32'd7, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFD, "divu 7/0");
    wait_idle(10, "divu 7/0");

    mt_write(MDU_MTLO, 32'h00001234, 32'hFFFFFFFF, 32'h00001234, "mtlo");
    mt_write(MDU_MTHI, 32'hCAFE0000, 32'hCAFE0000, 32'h00001234, "mthi");

    issue(MDU_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, "div 7/-2");
    wait_idle(10, "div 7/-2");
    issue(MDU_DIVU, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, "divu fffffff9/2");
    wait_idle(10, "divu");

    // MULTU with a start and an MTLO injected while busy: both must be ignored
    issue(MDU_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, "multu busy-inject");
    E_Start = 1'b1; E_HILOWr = 1'b1; E_MDUOp = MDU_MTLO; E_A = 32'h0000DEAD; E_B = 32'd1;
    D_IsMD = 1'b1;
    #1 check("stall busy D md", 32'(MD_Stall), 32'd1);
    @(negedge clk);
    E_Start = 1'b0; E_HILOWr = 1'b0; D_IsMD = 1'b0;
    #1 check("stall busy no D md", 32'(MD_Stall), 32'd0);
    check("lo held while busy", E_LO, 32'h7FFFFFFC);
    wait_idle(4, "multu busy-inject");

    // Unknown op with start: no busy, no write
    @(negedge clk);
    E_Start = 1'b1; E_MDUOp = 3'd7; E_A = 32'h11111111; E_B = 32'h2;
    @(negedge clk);
    E_Start = 1'b0;
    check("unknown op busy", 32'(E_Busy), 32'd0);
    check("unknown op HI", E_HI, 32'h00000001);
    check("unknown op LO", E_LO, 32'h00000000);

    // Start together with MTLO: start (a no-op here) wins, MTLO dropped
    @(negedge clk);
    E_Start = 1'b1; E_HILOWr = 1'b1; E_MDUOp = MDU_MTLO; E_A = 32'h00005555;
    @(negedge clk);
    E_Start = 1'b0; E_HILOWr = 1'b0;
    check("start+mtlo busy", 32'(E_Busy), 32'd0);
    check("start+mtlo LO", E_LO, 32'h00000000);

    issue(MDU_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, "mult -3*5");
    wait_idle(5, "mult -3*5");

    // Reset on the third busy cycle of a DIV: aborted op, so completion shows zeros
    issue(MDU_DIV, 32'd100, 32'd3, 32'h0, 32'h0, "div reset-abort");
    @(negedge clk);
    @(negedge clk);
    #3 reset = 1'b1;
    #1;
    check("async reset busy", 32'(E_Busy), 32'd0);
    check("async reset HI", E_HI, 32'h0);
    check("async reset LO", E_LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("no late commit busy", 32'(E_Busy), 32'd0);
    check("no late commit HI", E_HI, 32'h0);
    check("no late commit LO", E_LO, 32'h0);

    repeat (2) @(negedge clk);
    #3 check("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
